// File: rtl/lut_neuron_loader_if.sv
// rtl/lut_neuron_loader_if.sv - config stream and lookup handshake bundle for lut_neuron_loader
// cfg_parity exists only when LUT_PARITY_EN is defined
interface lut_neuron_loader_if #(
  parameter int IN_BITS          = 4,
  parameter int OUT_BITS         = 2,
  parameter int ENTRIES_PER_WORD = 4
);
  localparam int CFG_W = ENTRIES_PER_WORD * OUT_BITS;

  logic                cfg_start;
  logic                cfg_valid;
  logic [CFG_W-1:0]    cfg_data;
  logic                cfg_ready;
  logic                load_done;
  logic                cfg_err;
  logic                in_valid;
  logic [IN_BITS-1:0]  in_data;
  logic                in_ready;
  logic                out_valid;
  logic [OUT_BITS-1:0] out_data;
`ifdef LUT_PARITY_EN
  logic                cfg_parity;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_parity, in_valid, in_data,
    input  cfg_ready, load_done, cfg_err, in_ready, out_valid, out_data
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_parity, in_valid, in_data,
    output cfg_ready, load_done, cfg_err, in_ready, out_valid, out_data
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_ready, load_done, cfg_err, in_ready, out_valid, out_data
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_ready, load_done, cfg_err, in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/lut_neuron_loader.sv
// rtl/lut_neuron_loader.sv - run-time loadable truth-table neuron with registered lookups
// LUT_PARITY_EN adds per-word even parity checking with a sticky cfg_err
module lut_neuron_loader #(
  parameter int IN_BITS          = 4,
  parameter int OUT_BITS         = 2,
  parameter int ENTRIES_PER_WORD = 4
) (
  input logic                 clk,
  input logic                 rst,
  lut_neuron_loader_if.slave  bus
);
  localparam int CFG_W     = ENTRIES_PER_WORD * OUT_BITS;
  localparam int DEPTH     = 2 ** IN_BITS;
  localparam int NUM_WORDS = DEPTH / ENTRIES_PER_WORD;
  localparam int WADDR_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WADDR_W-1:0] LAST_WADDR = WADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    st_empty = 2'd0,
    st_load  = 2'd1,
    st_armed = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WADDR_W-1:0]   waddr_q, waddr_d;
  logic                 load_done_q, load_done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_ready_c;
  logic                 wr_en;
  logic                 par_ok;
  logic                 lookup;
  logic [OUT_BITS-1:0]  lut_q [DEPTH];
  logic                 out_valid_q;
  logic [OUT_BITS-1:0]  out_data_q;

`ifdef LUT_PARITY_EN
  assign par_ok = (bus.cfg_parity == ^bus.cfg_data);
`else
  assign par_ok = 1'b1;
`endif

  function automatic logic [IN_BITS-1:0] entry_addr(input logic [WADDR_W-1:0] w, input int k);
    return IN_BITS'(int'(w) * ENTRIES_PER_WORD + k);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= st_empty;
      waddr_q     <= '0;
      load_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      load_done_q <= load_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // cfg_start overrides everything, including a word presented in the same cycle
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    load_done_d = 1'b0;
    cfg_err_d   = cfg_err_q;
    cfg_ready_c = 1'b0;
    wr_en       = 1'b0;
    if (bus.cfg_start) begin
      state_d   = st_load;
      waddr_d   = '0;
      cfg_err_d = 1'b0;
    end else if (state_q == st_load) begin
      cfg_ready_c = 1'b1;
      if (bus.cfg_valid) begin
        if (!par_ok) begin
          state_d   = st_empty;
          waddr_d   = '0;
          cfg_err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (waddr_q == LAST_WADDR) begin
            state_d     = st_armed;
            waddr_d     = '0;
            load_done_d = 1'b1;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
    end
  end

  // Writes only happen in LOAD and lookups only in ARMED, so no bypass is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < ENTRIES_PER_WORD; k++)
        lut_q[entry_addr(waddr_q, k)] <= bus.cfg_data[k*OUT_BITS +: OUT_BITS];
    end
  end

  assign lookup = bus.in_valid && (state_q == st_armed);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= lookup;
      if (lookup) out_data_q <= lut_q[bus.in_data];
    end
  end

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.load_done = load_done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.in_ready  = (state_q == st_armed);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb/tb_lut_neuron_loader.sv - randomized self-checking bench for lut_neuron_loader
module tb_lut_neuron_loader;
  localparam int IN_BITS   = 4;
  localparam int OUT_BITS  = 2;
  localparam int EPW       = 4;
  localparam int CFG_W     = EPW * OUT_BITS;
  localparam int DEPTH     = 16;
  localparam int NUM_WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_neuron_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .ENTRIES_PER_WORD(EPW)) bus ();

  lut_neuron_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .ENTRIES_PER_WORD(EPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int model [DEPTH];
  logic [CFG_W-1:0] lw [NUM_WORDS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
`ifdef LUT_PARITY_EN
    bus.cfg_parity = 1'b0;
`endif
  endtask

  task automatic set_word(input logic [CFG_W-1:0] d, input logic par_bad);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
`ifdef LUT_PARITY_EN
    bus.cfg_parity = (^d) ^ par_bad;
`else
    if (par_bad) bus.cfg_data = d;
`endif
  endtask

  // Full table = word i entry k at address i*EPW+k, value = (word >> (k*OUT_BITS)) mod 2^OUT_BITS
  task automatic model_commit();
    for (int i = 0; i < NUM_WORDS; i++)
      for (int k = 0; k < EPW; k++)
        model[i*EPW + k] = (int'(lw[i]) >> (k*OUT_BITS)) % (1 << OUT_BITS);
  endtask

  task automatic load_words(input int max_gap);
    bus.cfg_start = 1'b1;
    set_word(CFG_W'($urandom), 1'b0);
    #1;
    total++; if (bus.cfg_ready !== 1'b0) $display("FAIL ready_in_start got=%0b exp=0", bus.cfg_ready); else passed++;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.cfg_valid = 1'b0;
        tick();
        total++; if (bus.load_done !== 1'b0) $display("FAIL done_in_gap got=%0b exp=0", bus.load_done); else passed++;
      end
      set_word(lw[i], 1'b0);
      #1;
      total++; if (bus.cfg_ready !== 1'b1) $display("FAIL ready_load word=%0d got=%0b exp=1", i, bus.cfg_ready); else passed++;
      tick();
      if (i < NUM_WORDS - 1) begin
        total++; if (bus.load_done !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL early_done word=%0d done=%0b in_ready=%0b exp=0/0", i, bus.load_done, bus.in_ready); else passed++;
      end else begin
        total++; if (bus.load_done !== 1'b1 || bus.in_ready !== 1'b1) $display("FAIL load_done done=%0b in_ready=%0b exp=1/1", bus.load_done, bus.in_ready); else passed++;
      end
    end
    bus.cfg_valid = 1'b0;
    model_commit();
    tick();
    total++; if (bus.load_done !== 1'b0) $display("FAIL done_pulse_width got=%0b exp=0", bus.load_done); else passed++;
  endtask

  task automatic do_lookup(input int a);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_BITS'(a);
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL in_ready_armed got=%0b exp=1", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1 || int'(bus.out_data) != model[a]) $display("FAIL lookup addr=%0h valid=%0b data=%0d exp=1/%0d", a, bus.out_valid, bus.out_data, model[a]); else passed++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if ({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.load_done, bus.cfg_err} !== 7'b0)
      $display("FAIL reset_outputs got=%b exp=0000000", {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.load_done, bus.cfg_err});
    else passed++;
  endtask

  task automatic test_empty_lookup();
    bus.in_valid = 1'b1;
    bus.in_data  = IN_BITS'($urandom);
    set_word(8'h3C, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0) $display("FAIL empty_ready in=%0b cfg=%0b exp=0/0", bus.in_ready, bus.cfg_ready); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL empty_out_valid got=%0b exp=0", bus.out_valid); else passed++;
    drive_idle();
  endtask

  task automatic test_load_basic();
    int addrs [6] = '{0, 3, 4, 7, 9, 15};
    int exps  [6] = '{0, 3, 3, 0, 0, 3};
    lw = '{8'hE4, 8'h1B, 8'h00, 8'hFF};
    load_words(0);
    for (int i = 0; i < 6; i++) begin
      total++; if (model[addrs[i]] != exps[i]) $display("FAIL model_vs_plan addr=%0h got=%0d exp=%0d", addrs[i], model[addrs[i]], exps[i]); else passed++;
      do_lookup(addrs[i]);
    end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 2'b11) $display("FAIL out_hold valid=%0b data=%0d exp=0/3", bus.out_valid, bus.out_data); else passed++;
  endtask

  task automatic test_armed_ignore();
    set_word(8'hAA, 1'b0);
    #1;
    total++; if (bus.cfg_ready !== 1'b0) $display("FAIL armed_cfg_ready got=%0b exp=0", bus.cfg_ready); else passed++;
    tick();
    bus.cfg_valid = 1'b0;
    total++; if (bus.load_done !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL armed_ignore done=%0b in_ready=%0b exp=0/1", bus.load_done, bus.in_ready); else passed++;
    do_lookup(1);
    total++; if (bus.out_data !== 2'b01) $display("FAIL armed_table_kept got=%0d exp=1", bus.out_data); else passed++;
  endtask

  task automatic test_restart();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_word(CFG_W'($urandom), 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = IN_BITS'($urandom);
      #1;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL load_in_ready got=%0b exp=0", bus.in_ready); else passed++;
      tick();
      total++; if (bus.out_valid !== 1'b0) $display("FAIL load_out_valid got=%0b exp=0", bus.out_valid); else passed++;
    end
    drive_idle();
    lw = '{8'h55, 8'h55, 8'h55, 8'h55};
    load_words(0);
    for (int a = 0; a < DEPTH; a++) begin
      do_lookup(a);
      total++; if (bus.out_data !== 2'b01) $display("FAIL restart_table addr=%0h got=%0d exp=1", a, bus.out_data); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int a;
    for (int i = 0; i < NUM_WORDS; i++) lw[i] = CFG_W'($urandom);
    load_words(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_data = IN_BITS'(i);
      tick();
      total++; if (bus.out_valid !== 1'b1 || int'(bus.out_data) != model[i]) $display("FAIL b2b addr=%0h valid=%0b data=%0d exp=1/%0d", i, bus.out_valid, bus.out_data, model[i]); else passed++;
    end
    a = $urandom_range(0, DEPTH-1);
    bus.in_data   = IN_BITS'(a);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || int'(bus.out_data) != model[a]) $display("FAIL start_cycle_lookup addr=%0h valid=%0b data=%0d exp=1/%0d", a, bus.out_valid, bus.out_data, model[a]); else passed++;
    for (int i = 0; i < NUM_WORDS; i++) lw[i] = CFG_W'($urandom);
    load_words(1);
    for (int i = 0; i < 4; i++) do_lookup($urandom_range(0, DEPTH-1));
  endtask

  task automatic test_reset_midload();
    lw = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_words(0);
    do_lookup(0);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_word(CFG_W'($urandom), 1'b0);
      tick();
    end
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_word(8'h12, 1'b0);
    #1;
    total++; if ({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.load_done, bus.cfg_err} !== 7'b0)
      $display("FAIL midload_reset got=%b exp=0000000", {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.out_data, bus.load_done, bus.cfg_err});
    else passed++;
    drive_idle();
    tick();
    test_load_basic();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int last;
      for (int i = 0; i < NUM_WORDS; i++) lw[i] = CFG_W'($urandom);
      load_words(2);
      last = -1;
      for (int n = 0; n < 10; n++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          tick();
          total++; if (bus.out_valid !== 1'b0 || (last >= 0 && int'(bus.out_data) != model[last])) $display("FAIL rand_idle valid=%0b data=%0d", bus.out_valid, bus.out_data); else passed++;
        end else begin
          last = $urandom_range(0, DEPTH-1);
          do_lookup(last);
        end
      end
    end
  endtask

`ifdef LUT_PARITY_EN
  task automatic test_parity();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    set_word(8'h01, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
    total++; if (bus.cfg_err !== 1'b1 || bus.in_ready !== 1'b0 || bus.load_done !== 1'b0) $display("FAIL parity_err err=%0b in_ready=%0b done=%0b exp=1/0/0", bus.cfg_err, bus.in_ready, bus.load_done); else passed++;
    set_word(8'h03, 1'b0);
    #1;
    total++; if (bus.cfg_ready !== 1'b0) $display("FAIL parity_empty_ready got=%0b exp=0", bus.cfg_ready); else passed++;
    tick();
    bus.cfg_valid = 1'b0;
    total++; if (bus.cfg_err !== 1'b1 || bus.load_done !== 1'b0) $display("FAIL parity_sticky err=%0b done=%0b exp=1/0", bus.cfg_err, bus.load_done); else passed++;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    total++; if (bus.cfg_err !== 1'b0) $display("FAIL parity_clear got=%0b exp=0", bus.cfg_err); else passed++;
    for (int i = 0; i < NUM_WORDS; i++) lw[i] = CFG_W'($urandom);
    load_words(0);
    for (int i = 0; i < 4; i++) do_lookup($urandom_range(0, DEPTH-1));
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    test_reset();
    test_empty_lookup();
    test_load_basic();
    test_armed_ignore();
    test_restart();
    test_back_to_back();
    test_reset_midload();
    test_random();
`ifdef LUT_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
